// File: rtl/nf10_oq_pkg.sv
`default_nettype none
// ============================================================================
// Package : nf10_oq_pkg
// Shared types and helpers for the BRAM output-queue stage.
// Rev     : 1.0 - initial release
// ============================================================================
package nf10_oq_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_WRITE = 1'b1
    } oq_state_t;

    // Low bit index of slice idx in a flattened bus of width-wide fields
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nf10_oq_bram.sv
`default_nettype none
// ============================================================================
// Module : nf10_oq_bram
// Simple dual-port packet store: one write port, one registered read port.
// Rev    : 1.0 - initial release
// ============================================================================
module nf10_oq_bram #(
    parameter int WIDTH     = 417,
    parameter int ADDR_BITS = 9
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [WIDTH-1:0]     rd_data
);

    logic [WIDTH-1:0] mem [0:(1 << ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/nf10_bram_output_queues_n.sv
`default_nettype none
// ============================================================================
// Module : nf10_bram_output_queues_n
// One-to-N AXI-Stream demux into per-queue store-and-forward BRAM FIFOs.
// Rev    : 1.0 - initial release
// ============================================================================
module nf10_bram_output_queues_n
    import nf10_oq_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int C_NUM_QUEUES         = 5,
    parameter int C_DEPTH_BITS         = 9,
    parameter int C_MAX_PKT_WORDS      = 48,
    parameter int C_DST_POS            = 24
) (
    input  logic                                          axi_aclk,
    input  logic                                          axi_reset,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]                s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]              s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]               s_axis_tuser,
    input  logic                                          s_axis_tvalid,
    output logic                                          s_axis_tready,
    input  logic                                          s_axis_tlast,
    output logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_NUM_QUEUES*C_S_AXIS_DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic [C_NUM_QUEUES*C_S_AXIS_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic [C_NUM_QUEUES-1:0]                       m_axis_tlast,
    output logic [C_NUM_QUEUES-1:0]                       m_axis_tvalid,
    input  logic [C_NUM_QUEUES-1:0]                       m_axis_tready,
    output logic [CNT_W*C_NUM_QUEUES-1:0]                 pkt_stored,
    output logic [CNT_W*C_NUM_QUEUES-1:0]                 pkt_dropped
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int TUW   = C_S_AXIS_TUSER_WIDTH;
    localparam int NQ    = C_NUM_QUEUES;
    localparam int PW    = C_DEPTH_BITS + 1;
    localparam int DEPTH = 1 << C_DEPTH_BITS;
    localparam int WW    = DW + SW + TUW + 1;

    oq_state_t       r_state;
    oq_state_t       w_state_nxt;
    logic [NQ-1:0]   r_accept;
    logic [NQ-1:0]   w_accept_nxt;
    logic            r_ready;
    logic            w_beat;
    logic            w_sop;
    logic [NQ-1:0]   w_dest;
    logic [NQ-1:0]   w_room;
    logic [NQ-1:0]   w_full;
    logic [NQ-1:0]   w_target;
    logic [NQ-1:0]   w_wr;
    logic [NQ-1:0]   w_ovf;
    logic [NQ-1:0]   w_refuse;
    logic [WW-1:0]   w_wdata;

    assign s_axis_tready = r_ready;
    assign w_beat   = s_axis_tvalid & r_ready;
    assign w_sop    = w_beat & (r_state == ST_IDLE);
    assign w_dest   = s_axis_tuser[C_DST_POS +: NQ];
    assign w_target = w_sop ? (w_dest & w_room) : r_accept;
    assign w_wr     = w_beat ? (w_target & ~w_full) : '0;
    assign w_ovf    = w_beat ? (w_target & w_full) : '0;
    assign w_refuse = w_sop ? (w_dest & ~w_room) : '0;
    assign w_wdata  = {s_axis_tlast, s_axis_tuser, s_axis_tstrb, s_axis_tdata};

    always_ff @(posedge axi_aclk or posedge axi_reset) begin
        if (axi_reset) begin
            r_ready  <= 1'b0;
            r_state  <= ST_IDLE;
            r_accept <= '0;
        end else begin
            r_ready  <= 1'b1;
            r_state  <= w_state_nxt;
            r_accept <= w_accept_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept_nxt = r_accept;
        if (w_beat) begin
            w_accept_nxt = w_target & ~w_full;
            w_state_nxt  = s_axis_tlast ? ST_IDLE : ST_WRITE;
        end
    end

    for (genvar q = 0; q < NQ; q++) begin : g_queue
        logic [PW-1:0]    r_wr_ptr;
        logic [PW-1:0]    r_start_ptr;
        logic [PW-1:0]    r_commit_ptr;
        logic [PW-1:0]    r_rd_ptr;
        logic [PW-1:0]    w_free;
        logic [CNT_W-1:0] r_stored;
        logic [CNT_W-1:0] r_dropped;
        logic [WW-1:0]    w_rdata;
        logic [WW-1:0]    r_buf0;
        logic [WW-1:0]    r_buf1;
        logic [1:0]       r_cnt;
        logic [1:0]       w_level;
        logic             r_pend;
        logic             w_pop;
        logic             w_rd_en;

        assign w_free    = PW'(DEPTH) - (r_wr_ptr - r_rd_ptr);
        assign w_room[q] = int'(w_free) >= C_MAX_PKT_WORDS;
        assign w_full[q] = (w_free == '0);

        // Only words behind the commit pointer belong to complete packets
        assign w_pop   = (r_cnt != 2'd0) && m_axis_tready[q];
        assign w_level = r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        assign w_rd_en = (r_rd_ptr != r_commit_ptr) && (w_level <= 2'd1);

        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                r_wr_ptr     <= '0;
                r_start_ptr  <= '0;
                r_commit_ptr <= '0;
                r_rd_ptr     <= '0;
                r_stored     <= '0;
                r_dropped    <= '0;
                r_pend       <= 1'b0;
            end else begin
                if (w_sop && w_dest[q]) begin
                    r_start_ptr <= r_wr_ptr;
                end
                if (w_ovf[q]) begin
                    r_wr_ptr <= r_start_ptr;
                end else if (w_wr[q]) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_wr[q] && s_axis_tlast) begin
                    r_commit_ptr <= r_wr_ptr + PW'(1);
                    r_stored     <= r_stored + CNT_W'(1);
                end
                if (w_ovf[q] || w_refuse[q]) begin
                    r_dropped <= r_dropped + CNT_W'(1);
                end
                if (w_rd_en) begin
                    r_rd_ptr <= r_rd_ptr + PW'(1);
                end
                r_pend <= w_rd_en;
            end
        end

        nf10_oq_bram #(
            .WIDTH     (WW),
            .ADDR_BITS (C_DEPTH_BITS)
        ) u_bram (
            .clk     (axi_aclk),
            .wr_en   (w_wr[q]),
            .wr_addr (r_wr_ptr[C_DEPTH_BITS-1:0]),
            .wr_data (w_wdata),
            .rd_en   (w_rd_en),
            .rd_addr (r_rd_ptr[C_DEPTH_BITS-1:0]),
            .rd_data (w_rdata)
        );

        // Two-entry skid buffer; r_buf0 always drives the output
        always_ff @(posedge axi_aclk or posedge axi_reset) begin
            if (axi_reset) begin
                r_cnt  <= 2'd0;
                r_buf0 <= '0;
                r_buf1 <= '0;
            end else begin
                case ({w_pop, r_pend})
                    2'b10: begin
                        r_buf0 <= r_buf1;
                        r_cnt  <= r_cnt - 2'd1;
                    end
                    2'b01: begin
                        if (r_cnt == 2'd0) begin
                            r_buf0 <= w_rdata;
                        end else begin
                            r_buf1 <= w_rdata;
                        end
                        r_cnt <= r_cnt + 2'd1;
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            r_buf0 <= w_rdata;
                        end else begin
                            r_buf0 <= r_buf1;
                            r_buf1 <= w_rdata;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end

        assign m_axis_tdata[slice_lo(q, DW) +: DW]     = r_buf0[DW-1:0];
        assign m_axis_tstrb[slice_lo(q, SW) +: SW]     = r_buf0[DW +: SW];
        assign m_axis_tuser[slice_lo(q, TUW) +: TUW]   = r_buf0[DW+SW +: TUW];
        assign m_axis_tlast[q]                         = r_buf0[WW-1];
        assign m_axis_tvalid[q]                        = (r_cnt != 2'd0);
        assign pkt_stored[slice_lo(q, CNT_W) +: CNT_W]  = r_stored;
        assign pkt_dropped[slice_lo(q, CNT_W) +: CNT_W] = r_dropped;
    end

endmodule
`default_nettype wire
